// File: rtl/sipo_frame_ctrl_if.sv
// Bundle of the frame controller's serial-in and parallel-out signals.
//   Serial side : start, si, si_en, clr_overrun  (into the controller)
//   Output side : dout / dout_valid / dout_ready  (valid/ready word port)
//   Status      : busy, bit_cnt, overrun
// The slave modport is the controller. The master modport is the
// source/consumer environment that surrounds it.
interface sipo_frame_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             start;
  logic             si;
  logic             si_en;
  logic             dout_ready;
  logic             clr_overrun;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;

  modport slave (
    input  start, si, si_en, dout_ready, clr_overrun,
    output dout, dout_valid, busy, bit_cnt, overrun
  );

  modport master (
    output start, si, si_en, dout_ready, clr_overrun,
    input  dout, dout_valid, busy, bit_cnt, overrun
  );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Framed serial-in/parallel-out capture controller.
// Ports:
//   clk, rst_n : rising-edge clock and synchronous active-low reset.
//   bus        : sipo_frame_ctrl_if slave. It carries the serial strobe
//                inputs, the one-word valid/ready output buffer, and the
//                busy, bit_cnt and overrun status.
// A start pulse opens a frame. The next WIDTH strobed bits are shifted in
// MSB first. The finished word moves to the output buffer when that buffer
// is free. If the buffer is still blocked, the word waits in the shift
// register (HOLD). Any bit strobed during that wait is dropped, and the
// drop is recorded in the sticky overrun flag.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sipo_frame_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             overrun_q, overrun_d;

  logic             buf_free;
  logic [WIDTH-1:0] sreg_shifted;
  logic             drop;

  // The buffer can take a new word when it is empty, or when the word it
  // holds is being accepted in this same cycle.
  assign buf_free     = !dout_valid_q || bus.dout_ready;
  assign sreg_shifted = {sreg_q[WIDTH-2:0], bus.si};
  assign drop         = (state_q == HOLD) && bus.si_en;

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    dout_d       = dout_q;
    bit_cnt_d    = bit_cnt_q;
    dout_valid_d = dout_valid_q && !bus.dout_ready;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        // A start here restarts the frame, and any same-cycle bit is lost.
        if (bus.start) begin
          bit_cnt_d = '0;
        end else if (bus.si_en) begin
          sreg_d = sreg_shifted;
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            if (buf_free) begin
              dout_d       = sreg_shifted;
              dout_valid_d = 1'b1;
              bit_cnt_d    = '0;
              state_d      = IDLE;
            end else begin
              bit_cnt_d = CW'(WIDTH);
              state_d   = HOLD;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (buf_free) begin
          dout_d       = sreg_q;
          dout_valid_d = 1'b1;
          bit_cnt_d    = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // When a drop and a clear arrive together, the drop wins so that no
    // lost bit goes unreported.
    overrun_d = overrun_q;
    if (bus.clr_overrun) overrun_d = 1'b0;
    if (drop)            overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl with WIDTH=4. The stimulus pushes
// each expected word into a queue. An independent monitor pops that queue
// and compares the word on every output transfer. The monitor also checks
// that dout stays stable while the consumer stalls.
module tb_sipo_frame_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sipo_frame_ctrl_if #(.WIDTH(W)) bus ();

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  logic           prev_stall = 1'b0;
  logic [W-1:0]   prev_dout  = '0;
  logic [W-1:0]   popped;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", {31'd0, bus.dout_valid}, 32'd1);
        chk("stall_dout_stable", {28'd0, bus.dout}, {28'd0, prev_dout});
      end
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {28'd0, bus.dout}, 32'hFFFF_FFFF);
        end else begin
          popped = exp_q.pop_front();
          chk("word", {28'd0, bus.dout}, {28'd0, popped});
        end
      end
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout  = bus.dout;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.si    = b;
    bus.si_en = 1'b1;
    step();
    bus.si_en = 1'b0;
    bus.si    = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    logic [W-1:0] t;
    t = w;
    for (int i = W - 1; i >= 0; i--) send_bit(t[i]);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.si          = 1'b0;
    bus.si_en       = 1'b0;
    bus.dout_ready  = 1'b0;
    bus.clr_overrun = 1'b0;

    // Reset held for two clocks while the inputs take random values.
    for (int i = 0; i < 2; i++) begin
      bus.start       = 1'($urandom);
      bus.si          = 1'($urandom);
      bus.si_en       = 1'($urandom);
      bus.dout_ready  = 1'($urandom);
      bus.clr_overrun = 1'($urandom);
      step();
    end
    chk("rst_dout",    {28'd0, bus.dout},   32'd0);
    chk("rst_valid",   {31'd0, bus.dout_valid}, 32'd0);
    chk("rst_busy",    {31'd0, bus.busy},   32'd0);
    chk("rst_bit_cnt", {29'd0, bus.bit_cnt}, 32'd0);
    chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    bus.start = 1'b0; bus.si = 1'b0; bus.si_en = 1'b0;
    bus.dout_ready = 1'b0; bus.clr_overrun = 1'b0;
    rst_n = 1'b1;
    step();

    // Basic frame. A strobe in the start cycle must be ignored.
    bus.dout_ready = 1'b1;
    exp_q.push_back(4'b1011);
    bus.si = 1'b1; bus.si_en = 1'b1;
    pulse_start();
    bus.si_en = 1'b0;
    chk("start_bit_ignored", {29'd0, bus.bit_cnt}, 32'd0);
    chk("busy_in_shift", {31'd0, bus.busy}, 32'd1);
    send_word(4'b1011);
    chk("basic_valid", {31'd0, bus.dout_valid}, 32'd1);
    chk("basic_dout",  {28'd0, bus.dout}, 32'hB);
    chk("basic_busy",  {31'd0, bus.busy}, 32'd0);
    step();
    chk("basic_valid_one_cycle", {31'd0, bus.dout_valid}, 32'd0);

    // Backpressure: the first word sits in the buffer and the second
    // word parks in HOLD.
    bus.dout_ready = 1'b0;
    exp_q.push_back(4'b1100);
    pulse_start();
    send_word(4'b1100);
    chk("bp1_valid", {31'd0, bus.dout_valid}, 32'd1);
    exp_q.push_back(4'b0110);
    pulse_start();
    send_word(4'b0110);
    chk("hold_busy",    {31'd0, bus.busy}, 32'd1);
    chk("hold_bit_cnt", {29'd0, bus.bit_cnt}, 32'd4);
    chk("hold_dout",    {28'd0, bus.dout}, 32'hC);
    pulse_start();
    chk("hold_start_ignored", {29'd0, bus.bit_cnt}, 32'd4);

    // Overrun while holding.
    send_bit(1'b1);
    send_bit(1'b0);
    chk("overrun_set", {31'd0, bus.overrun}, 32'd1);
    step();
    chk("overrun_sticky", {31'd0, bus.overrun}, 32'd1);
    chk("hold_dout_kept", {28'd0, bus.dout}, 32'hC);
    bus.clr_overrun = 1'b1;
    step();
    bus.clr_overrun = 1'b0;
    chk("overrun_clr", {31'd0, bus.overrun}, 32'd0);
    bus.clr_overrun = 1'b1;
    send_bit(1'b1);
    bus.clr_overrun = 1'b0;
    chk("overrun_set_wins", {31'd0, bus.overrun}, 32'd1);
    bus.clr_overrun = 1'b1;
    step();
    bus.clr_overrun = 1'b0;

    // Release: 1100 goes out and 0110 loads on the same edge.
    bus.dout_ready = 1'b1;
    step();
    chk("release_dout",  {28'd0, bus.dout}, 32'h6);
    chk("release_valid", {31'd0, bus.dout_valid}, 32'd1);
    chk("release_busy",  {31'd0, bus.busy}, 32'd0);
    step();
    chk("release_drained", {31'd0, bus.dout_valid}, 32'd0);

    // Restart in mid-frame.
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b0);
    chk("restart_cnt2", {29'd0, bus.bit_cnt}, 32'd2);
    pulse_start();
    chk("restart_cnt0", {29'd0, bus.bit_cnt}, 32'd0);
    exp_q.push_back(4'b0111);
    send_word(4'b0111);
    chk("restart_dout", {28'd0, bus.dout}, 32'h7);
    step();

    // Reset in mid-frame.
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("mid_cnt3", {29'd0, bus.bit_cnt}, 32'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_cnt",   {29'd0, bus.bit_cnt}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.dout_valid}, 32'd0);
    exp_q.push_back(4'b1001);
    pulse_start();
    send_word(4'b1001);
    chk("post_rst_dout", {28'd0, bus.dout}, 32'h9);
    repeat (3) step();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Sequences a WIDTH-bit serial-in/parallel-out shift chain for framed serial capture.
- Counts strobed serial bits, assembles one word per frame, and presents it on a valid/ready output port through a one-word output buffer.
- Flags bits lost while the buffer is blocked.
- Sits between a serial bit source and any parallel consumer in the shift-register datapath.

Parameters:
- WIDTH, 4, bits per frame; legal range 2 to 32.
- CW, $clog2(WIDTH+1), width of bit_cnt; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a new frame; pulse.
- si  input  1  serial data bit.
- si_en  input  1  bit strobe; si is sampled when high.
- dout_ready  input  1  consumer accepts dout.
- clr_overrun  input  1  clears the sticky overrun flag.
- dout  output  WIDTH  assembled parallel word.
- dout_valid  output  1  dout holds an unconsumed word.
- busy  output  1  frame in progress or pending transfer (state != IDLE).
- bit_cnt  output  CW  bits captured in the current frame.
- overrun  output  1  sticky: a bit was dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; shift register, dout, bit_cnt = 0; dout_valid=0; overrun=0. Reset mid-frame discards the partial frame and any held word.
- Shift order matches the existing chain: sreg <= {sreg[WIDTH-2:0], si}. The first bit received ends in dout[WIDTH-1]; the last bit ends in dout[0].
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - start=1 -> SHIFT, bit_cnt=0.
  - si_en is ignored, including in the start cycle; the first captured bit is the next si_en after start.
- SHIFT:
  - start=1 has priority: abort the frame, bit_cnt=0, stay in SHIFT, and ignore the same-cycle si_en.
  - Otherwise si_en=1 shifts si in and increments bit_cnt.
  - On the WIDTH-th bit, if the buffer is free (dout_valid=0, or dout_valid=1 and dout_ready=1 this cycle): dout <= completed word, dout_valid=1, bit_cnt=0, go to IDLE.
  - On the WIDTH-th bit with the buffer blocked: keep the word in sreg, go to HOLD, and bit_cnt holds at WIDTH.
- HOLD:
  - When the buffer becomes free by the same rule: dout <= sreg, dout_valid=1, bit_cnt=0, go to IDLE.
  - si_en=1 sets overrun and the bit is dropped.
  - start is ignored.
- Output handshake:
  - A transfer occurs when dout_valid=1 and dout_ready=1.
  - On a transfer, dout_valid clears next cycle unless a new word loads in the same cycle, in which case it stays 1 with the new dout.
  - dout is stable while dout_valid=1 and not yet accepted.
- Latency: dout_valid rises on the clock edge that samples the final si_en, given a free buffer.
- Throughput: back-to-back frames need one start cycle each; maximum rate is WIDTH+1 cycles per word.
- overrun:
  - Set by a dropped bit. clr_overrun clears it.
  - Simultaneous set and clear: set wins.
- busy is combinational from state.
- bit_cnt is registered.

Test Plan:
- Reset: hold rst_n=0 for 2 clks with random inputs -> dout=0, dout_valid=0, busy=0, bit_cnt=0, overrun=0.
- Basic frame, WIDTH=4, dout_ready=1: start, then si=1,0,1,1 on 4 consecutive si_en -> dout=4'b1011, dout_valid=1 for exactly one cycle, busy=0 after.
- Backpressure: dout_ready=0; frame 4'b1100 completes, then start and frame 4'b0110 complete -> state HOLD, dout=1100. Raise dout_ready -> next cycle dout=0110, dout_valid=1, busy=0.
- Overrun: in HOLD, pulse si_en twice -> overrun=1 and stays sticky. clr_overrun -> 0. Set and clear in the same cycle -> overrun=1.
- Restart: start, shift 2 bits, start again, then 4 bits 0,1,1,1 -> dout=4'b0111 and bit_cnt reached 2 before the restart cleared it.
- Reset mid-frame: after 3 bits assert rst_n=0 for one clk -> IDLE, no dout_valid, bit_cnt=0. A following full frame assembles correctly.
